// File: rtl/button_debouncer_pkg.sv
// Shared helpers for the button debouncer: cycle-count derivation and
// counter sizing. Optional long-press detection is enabled by defining
// BUTTON_DEBOUNCER_LONG_PRESS_EN.
package button_debouncer_pkg;

    // Number of consecutive differing samples needed before a level is accepted.
    function automatic int stable_cycles(input int freq, input int us);
        int cycles;
        cycles = (freq / 1000000) * us;
        if (cycles < 1) begin
            cycles = 1;
        end
        return cycles;
    endfunction

    // Number of cycles a debounced high level must persist to count as a long press.
    function automatic int long_cycles(input int freq, input int ms);
        int cycles;
        cycles = (freq / 1000) * ms;
        if (cycles < 1) begin
            cycles = 1;
        end
        return cycles;
    endfunction

    // Width able to hold 0..max_value, never narrower than one bit.
    function automatic int counter_width(input int max_value);
        if (max_value < 1) begin
            return 1;
        end
        return $clog2(max_value + 1);
    endfunction

endpackage : button_debouncer_pkg

// File: rtl/debounce_channel.sv
// One channel of the button debouncer: synchroniser, stability filter,
// registered edge pulses and, when BUTTON_DEBOUNCER_LONG_PRESS_EN is
// defined, a saturating hold counter driving long_press.
module debounce_channel #(
    parameter int   STABLE_CYCLES = 1,
    parameter int   COUNT_WIDTH   = 1,
    parameter int   SYNC_STAGES   = 2,
    parameter logic RESET_LEVEL   = 1'b0
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
   ,parameter int   LONG_CYCLES   = 1,
    parameter int   LONG_WIDTH    = 1
`endif
) (
    input  logic clock,
    input  logic reset,
    input  logic button_in,
    output logic button_out,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic long_press
);

    // Filter terminal count: the flip happens when this many prior differing
    // samples have been counted and one more differing sample arrives.
    localparam logic [COUNT_WIDTH-1:0] COUNT_LAST = COUNT_WIDTH'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sync_s;
    logic                   state_q, state_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    assign sync_s = sync_q[SYNC_STAGES-1];

    // Next-state for synchroniser, filter counter, debounced level and pulses.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], button_in};
        state_d = state_q;
        count_d = '0;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync_s != state_q) begin
            if (count_q == COUNT_LAST) begin
                state_d = sync_s;
                rise_d  = sync_s;
                fall_d  = ~sync_s;
            end else begin
                count_d = count_q + COUNT_WIDTH'(1);
            end
        end
    end

    // Registers; synchroniser resets to the channel's idle level so no edge follows reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q  <= {SYNC_STAGES{RESET_LEVEL}};
            state_q <= RESET_LEVEL;
            count_q <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            count_q <= count_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign button_out = state_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
    localparam logic [LONG_WIDTH-1:0] HOLD_MAX = LONG_WIDTH'(LONG_CYCLES);

    logic [LONG_WIDTH-1:0] hold_q, hold_d;
    logic                  long_q, long_d;

    // Hold counter follows the next debounced level so long_press drops with fall_pulse.
    always_comb begin
        hold_d = hold_q;
        if (!state_d) begin
            hold_d = '0;
        end else if (state_q && (hold_q != HOLD_MAX)) begin
            hold_d = hold_q + LONG_WIDTH'(1);
        end
        long_d = (hold_d == HOLD_MAX);
    end

    // Hold counter and long-press level registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign long_press = long_q;
`else
    assign long_press = 1'b0;
`endif

endmodule : debounce_channel

// File: rtl/button_debouncer.sv
// Multi-channel input conditioner for asynchronous board inputs. Derives
// cycle counts from the clock frequency and instantiates one independent
// debounce_channel per input bit. Long-press detection is included only
// when BUTTON_DEBOUNCER_LONG_PRESS_EN is defined.
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int                  CHANNELS           = 2,
    parameter int                  CLOCK_FREQUENCY    = 12000000,
    parameter int                  DEBOUNCE_TIME_US   = 10000,
    parameter int                  SYNC_STAGES        = 2,
    parameter logic [CHANNELS-1:0] RESET_VALUE        = {CHANNELS{1'b0}},
    parameter int                  LONG_PRESS_TIME_MS = 1000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] button_in,
    output logic [CHANNELS-1:0] button_out,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse,
    output logic [CHANNELS-1:0] long_press
);

    localparam int STABLE_CYCLES = stable_cycles(CLOCK_FREQUENCY, DEBOUNCE_TIME_US);
    localparam int COUNT_WIDTH   = counter_width(STABLE_CYCLES);
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
    localparam int LONG_CYCLES   = long_cycles(CLOCK_FREQUENCY, LONG_PRESS_TIME_MS);
    localparam int LONG_WIDTH    = counter_width(LONG_CYCLES);
`endif

    // Reject configurations the channel logic cannot build.
    if (CHANNELS < 1 || SYNC_STAGES < 2 || LONG_PRESS_TIME_MS < 1) begin : g_param_check
        $error("button_debouncer: invalid parameter set");
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .COUNT_WIDTH   (COUNT_WIDTH),
            .SYNC_STAGES   (SYNC_STAGES),
            .RESET_LEVEL   (RESET_VALUE[i])
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
           ,.LONG_CYCLES   (LONG_CYCLES),
            .LONG_WIDTH    (LONG_WIDTH)
`endif
        ) u_ch (
            .clock      (clock),
            .reset      (reset),
            .button_in  (button_in[i]),
            .button_out (button_out[i]),
            .rise_pulse (rise_pulse[i]),
            .fall_pulse (fall_pulse[i]),
            .long_press (long_press[i])
        );
    end

endmodule : button_debouncer

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer at 1 MHz / 10 us (10 stable cycles),
// two synchroniser stages. Long-press expectations follow whether
// BUTTON_DEBOUNCER_LONG_PRESS_EN is defined.
module tb_button_debouncer;

`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
    localparam logic LP_EN = 1'b1;
`else
    localparam logic LP_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] btn_a, out_a, rise_a, fall_a, long_a;
    logic [3:0] btn_b, out_b, rise_b, fall_b, long_b;
    logic [0:0] btn_c, out_c, rise_c, fall_c, long_c;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    button_debouncer #(
        .CHANNELS(2), .CLOCK_FREQUENCY(1000000), .DEBOUNCE_TIME_US(10),
        .SYNC_STAGES(2), .RESET_VALUE(2'b00), .LONG_PRESS_TIME_MS(1)
    ) dut_a (
        .clock(clock), .reset(reset), .button_in(btn_a), .button_out(out_a),
        .rise_pulse(rise_a), .fall_pulse(fall_a), .long_press(long_a)
    );

    button_debouncer #(
        .CHANNELS(4), .CLOCK_FREQUENCY(1000000), .DEBOUNCE_TIME_US(10),
        .SYNC_STAGES(2), .RESET_VALUE(4'b1010), .LONG_PRESS_TIME_MS(1)
    ) dut_b (
        .clock(clock), .reset(reset), .button_in(btn_b), .button_out(out_b),
        .rise_pulse(rise_b), .fall_pulse(fall_b), .long_press(long_b)
    );

    button_debouncer #(
        .CHANNELS(1), .CLOCK_FREQUENCY(1000000), .DEBOUNCE_TIME_US(1),
        .SYNC_STAGES(2), .RESET_VALUE(1'b0), .LONG_PRESS_TIME_MS(1)
    ) dut_c (
        .clock(clock), .reset(reset), .button_in(btn_c), .button_out(out_c),
        .rise_pulse(rise_c), .fall_pulse(fall_c), .long_press(long_c)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        btn_a = 2'b00;
        btn_b = 4'b1010;
        btn_c = 1'b0;
        repeat (3) @(negedge clock);

        chk("rst_out_a",  32'(out_a),  32'h0);
        chk("rst_rise_a", 32'(rise_a), 32'h0);
        chk("rst_fall_a", 32'(fall_a), 32'h0);
        chk("rst_long_a", 32'(long_a), 32'h0);
        chk("rst_out_b",  32'(out_b),  32'ha);
        chk("rst_out_c",  32'(out_c),  32'h0);
        reset = 1'b0;

        repeat (3) @(negedge clock);
        chk("idle_out_b",  32'(out_b),  32'ha);
        chk("idle_rise_b", 32'(rise_b), 32'h0);
        chk("idle_fall_b", 32'(fall_b), 32'h0);

        // Clean press on channel 0 of A and on the single-cycle filter C.
        btn_a[0] = 1'b1;
        btn_c    = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clock);
            chk("press_wait_out",  32'(out_a),  32'h0);
            chk("press_wait_rise", 32'(rise_a), 32'h0);
            chk("s1_out",  32'(out_c),  (i >= 3) ? 32'h1 : 32'h0);
            chk("s1_rise", 32'(rise_c), (i == 3) ? 32'h1 : 32'h0);
        end
        @(negedge clock);
        chk("press_out",  32'(out_a),  32'h1);
        chk("press_rise", 32'(rise_a), 32'h1);
        chk("press_fall", 32'(fall_a), 32'h0);

        // Hold for the long-press threshold.
        for (int k = 1; k <= 999; k++) begin
            @(negedge clock);
            chk("hold_long", 32'(long_a), 32'h0);
            chk("hold_out",  32'(out_a),  32'h1);
            chk("hold_rise", 32'(rise_a), 32'h0);
        end
        @(negedge clock);
        chk("long_rise", 32'(long_a), 32'(LP_EN));
        chk("long_out",  32'(out_a),  32'h1);

        // Release clears long_press together with fall_pulse.
        btn_a[0] = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clock);
            chk("rel_wait_out",  32'(out_a),  32'h1);
            chk("rel_wait_long", 32'(long_a), 32'(LP_EN));
        end
        @(negedge clock);
        chk("rel_out",  32'(out_a),  32'h0);
        chk("rel_fall", 32'(fall_a), 32'h1);
        chk("rel_rise", 32'(rise_a), 32'h0);
        chk("rel_long", 32'(long_a), 32'h0);
        @(negedge clock);
        chk("rel_fall_end", 32'(fall_a), 32'h0);

        // Bounce on channel 1: high 9, low 1, high 9, then low.
        for (int i = 0; i < 33; i++) begin
            btn_a[1] = (i < 9) || (i >= 10 && i < 19);
            @(negedge clock);
            chk("bounce_out",  32'(out_a[1]),  32'h0);
            chk("bounce_rise", 32'(rise_a[1]), 32'h0);
            chk("bounce_fall", 32'(fall_a[1]), 32'h0);
        end
        btn_a[1] = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clock);
            chk("settle_wait_out", 32'(out_a[1]), 32'h0);
        end
        @(negedge clock);
        chk("settle_out",  32'(out_a),  32'h2);
        chk("settle_rise", 32'(rise_a), 32'h2);

        // Reset mid-count on channel 0 discards progress.
        btn_a[0] = 1'b1;
        repeat (7) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("midrst_out_a",  32'(out_a),  32'h0);
        chk("midrst_rise_a", 32'(rise_a), 32'h0);
        chk("midrst_fall_a", 32'(fall_a), 32'h0);
        chk("midrst_out_b",  32'(out_b),  32'ha);
        reset = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clock);
            chk("midrst_wait_out", 32'(out_a[0]), 32'h0);
        end
        @(negedge clock);
        chk("midrst_flip_out",  32'(out_a),  32'h3);
        chk("midrst_flip_rise", 32'(rise_a), 32'h3);

        // Four channels flipping together from 1010 to 0101.
        btn_b = 4'b0101;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clock);
            chk("multi_wait_out",  32'(out_b),  32'ha);
            chk("multi_wait_rise", 32'(rise_b), 32'h0);
        end
        @(negedge clock);
        chk("multi_out",  32'(out_b),  32'h5);
        chk("multi_rise", 32'(rise_b), 32'h5);
        chk("multi_fall", 32'(fall_b), 32'ha);
        @(negedge clock);
        chk("multi_rise_end", 32'(rise_b), 32'h0);
        chk("multi_fall_end", 32'(fall_b), 32'h0);
        chk("multi_long",     32'(long_b), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_button_debouncer
